// File: rtl/adc_scan_sequencer_if.sv
// Request/result and converter-side signals of the ADC scan sequencer.
interface adc_scan_sequencer_if #(
   parameter int N_CH  = 4,
   parameter int CH_W  = 2,
   parameter int CNT_W = 12
);
   logic [N_CH-1:0]  req;
   logic             ld;
   logic [CNT_W-1:0] count;
   logic             inicio;
   logic [CH_W-1:0]  ch_sel;
   logic             busy;
   logic             res_valid;
   logic [CH_W-1:0]  res_ch;
   logic [CNT_W-1:0] res_data;
   logic             res_err;
   logic [N_CH-1:0]  ack;

   modport slave (
      input  req, ld, count,
      output inicio, ch_sel, busy, res_valid, res_ch, res_data, res_err, ack
   );

   modport master (
      output req, ld, count,
      input  inicio, ch_sel, busy, res_valid, res_ch, res_data, res_err, ack
   );
endinterface

// File: rtl/adc_scan_sequencer.sv
// Round-robin scheduler sharing one dual-slope converter across N_CH channels:
// select mux, settle, pulse inicio, wait for the ld rising edge (or time out),
// then report the tagged result and ack the requester. All outputs registered.
// The interface instance must be built with the same N_CH/CH_W/CNT_W values.
module adc_scan_sequencer #(
   parameter int N_CH       = 4,
   parameter int CH_W       = 2,
   parameter int CNT_W      = 12,
   parameter int SETTLE_CYC = 4,
   parameter int TIMEOUT    = 8192
) (
   input logic                 ck,
   input logic                 rst,
   adc_scan_sequencer_if.slave bus
);

   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int WW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_START,
      S_WAIT,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [CH_W-1:0]  ch_sel_q, ch_sel_d;
   logic [CH_W-1:0]  rr_q, rr_d;
   logic [SW-1:0]    scnt_q, scnt_d;
   logic [WW-1:0]    wcnt_q, wcnt_d;
   logic             ld_q;
   logic             inicio_q, inicio_d;
   logic             busy_q, busy_d;
   logic             res_valid_q, res_valid_d;
   logic [CH_W-1:0]  res_ch_q, res_ch_d;
   logic [CNT_W-1:0] res_data_q, res_data_d;
   logic             res_err_q, res_err_d;
   logic [N_CH-1:0]  ack_q, ack_d;

   logic [CH_W-1:0]  grant;
   logic [CH_W-1:0]  idx;
   logic             found;
   logic             ld_rise;

   assign ld_rise = bus.ld & ~ld_q;

   // Round-robin arbiter: first requesting channel at or above rr_q, wrapping.
   always_comb begin
      grant = rr_q;
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         idx = rr_q + CH_W'(i);
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            grant = idx;
         end
      end
   end

   // Next-state and registered-output logic; outputs are computed for the
   // state being entered so they line up with it cycle for cycle.
   always_comb begin
      state_d     = state_q;
      ch_sel_d    = ch_sel_q;
      rr_d        = rr_q;
      scnt_d      = scnt_q;
      wcnt_d      = wcnt_q;
      inicio_d    = 1'b0;
      res_valid_d = 1'b0;
      res_ch_d    = res_ch_q;
      res_data_d  = res_data_q;
      res_err_d   = res_err_q;
      ack_d       = '0;
      case (state_q)
         S_IDLE: begin
            if (|bus.req) begin
               ch_sel_d = grant;
               scnt_d   = '0;
               state_d  = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (scnt_q == SW'(SETTLE_CYC - 1)) begin
               inicio_d = 1'b1;
               state_d  = S_START;
            end else begin
               scnt_d = scnt_q + 1'b1;
            end
         end
         S_START: begin
            wcnt_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // The edge is tested first so it wins over a same-cycle timeout.
            if (ld_rise) begin
               res_data_d = bus.count;
               res_err_d  = 1'b0;
               state_d    = S_DONE;
            end else if (wcnt_q == WW'(TIMEOUT - 1)) begin
               res_data_d = '0;
               res_err_d  = 1'b1;
               state_d    = S_DONE;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
            if (state_d == S_DONE) begin
               res_valid_d = 1'b1;
               res_ch_d    = ch_sel_q;
               ack_d       = N_CH'(1) << ch_sel_q;
            end
         end
         S_DONE: begin
            rr_d    = ch_sel_q + 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge ck) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ch_sel_q    <= '0;
         rr_q        <= '0;
         scnt_q      <= '0;
         wcnt_q      <= '0;
         ld_q        <= 1'b0;
         inicio_q    <= 1'b0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_ch_q    <= '0;
         res_data_q  <= '0;
         res_err_q   <= 1'b0;
         ack_q       <= '0;
      end else begin
         state_q     <= state_d;
         ch_sel_q    <= ch_sel_d;
         rr_q        <= rr_d;
         scnt_q      <= scnt_d;
         wcnt_q      <= wcnt_d;
         ld_q        <= bus.ld;
         inicio_q    <= inicio_d;
         busy_q      <= busy_d;
         res_valid_q <= res_valid_d;
         res_ch_q    <= res_ch_d;
         res_data_q  <= res_data_d;
         res_err_q   <= res_err_d;
         ack_q       <= ack_d;
      end
   end

   assign bus.inicio    = inicio_q;
   assign bus.ch_sel    = ch_sel_q;
   assign bus.busy      = busy_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_ch    = res_ch_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_err   = res_err_q;
   assign bus.ack       = ack_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Self-checking bench for adc_scan_sequencer: directed scenarios plus a
// randomized run, all checked against a transaction-level reference model.
module tb_adc_scan_sequencer;

   localparam int N_CH   = 4;
   localparam int CH_W   = 2;
   localparam int CNT_W  = 12;
   localparam int SETTLE = 4;
   localparam int TO     = 128;

   logic ck  = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   int   ptr      = 0;

   always #5 ck = ~ck;

   adc_scan_sequencer_if #(.N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W)) bus ();

   adc_scan_sequencer #(
      .N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W),
      .SETTLE_CYC(SETTLE), .TIMEOUT(TO)
   ) dut (
      .ck(ck),
      .rst(rst),
      .bus(bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge ck);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".inicio"},    32'(bus.inicio),    32'd0);
      chk({tag, ".ch_sel"},    32'(bus.ch_sel),    32'd0);
      chk({tag, ".busy"},      32'(bus.busy),      32'd0);
      chk({tag, ".res_valid"}, 32'(bus.res_valid), 32'd0);
      chk({tag, ".res_ch"},    32'(bus.res_ch),    32'd0);
      chk({tag, ".res_data"},  32'(bus.res_data),  32'd0);
      chk({tag, ".res_err"},   32'(bus.res_err),   32'd0);
      chk({tag, ".ack"},       32'(bus.ack),       32'd0);
   endtask

   // Reference: first requesting channel from the pointer, wrapping.
   function automatic int model_grant(input logic [N_CH-1:0] r, input int p);
      for (int i = 0; i < N_CH; i++) begin
         if (r[(p + i) % N_CH]) return (p + i) % N_CH;
      end
      return -1;
   endfunction

   // ld level during WAIT cycle k (k = -1 is the START cycle).
   function automatic bit wave(input bit hi0, input int fall, input int rise, input int k);
      if (rise >= 0 && k >= rise) return 1'b1;
      if (hi0 && k < fall) return 1'b1;
      return 1'b0;
   endfunction

   // WAIT cycle index of the first qualifying rising edge, -1 if none in time.
   function automatic int edge_at(input bit hi0, input int fall, input int rise);
      for (int k = 0; k < TO; k++) begin
         if (wave(hi0, fall, rise, k) && !wave(hi0, fall, rise, k - 1)) return k;
      end
      return -1;
   endfunction

   // One full conversion starting from IDLE with req=r driven in cycle 0.
   // keep: requester holds req after ack; drop: granted bit falls during SETTLE.
   task automatic conv(input string tag, input logic [N_CH-1:0] r, input bit keep,
                       input bit drop, input bit hi0, input int fall, input int rise,
                       input logic [CNT_W-1:0] data, output int g);
      int          e, d, k;
      bit          err;
      logic [CNT_W-1:0] xdata;
      g     = model_grant(r, ptr);
      e     = edge_at(hi0, fall, rise);
      err   = (e < 0);
      d     = SETTLE + 2 + (err ? TO : e + 1);
      xdata = err ? '0 : data;
      bus.req   = r;
      bus.ld    = hi0;
      bus.count = CNT_W'($urandom);
      for (int c = 1; c <= d + 1; c++) begin
         step();
         k = c - (SETTLE + 2);
         if (c <= d) chk({tag, ".ch_sel"}, 32'(bus.ch_sel), 32'(g));
         if (c == SETTLE + 1) chk({tag, ".inicio_pulse"}, 32'(bus.inicio), 32'd1);
         else                 chk({tag, ".inicio_quiet"}, 32'(bus.inicio), 32'd0);
         if (c < d) begin
            chk({tag, ".busy"},      32'(bus.busy),      32'd1);
            chk({tag, ".res_valid"}, 32'(bus.res_valid), 32'd0);
            chk({tag, ".ack_quiet"}, 32'(bus.ack),       32'd0);
         end else if (c == d) begin
            chk({tag, ".done_busy"},  32'(bus.busy),      32'd1);
            chk({tag, ".res_valid1"}, 32'(bus.res_valid), 32'd1);
            chk({tag, ".res_ch"},     32'(bus.res_ch),    32'(g));
            chk({tag, ".res_data"},   32'(bus.res_data),  32'(xdata));
            chk({tag, ".res_err"},    32'(bus.res_err),   32'(err));
            chk({tag, ".ack"},        32'(bus.ack),       32'(N_CH'(1) << g));
         end else begin
            chk({tag, ".idle_busy"},   32'(bus.busy),      32'd0);
            chk({tag, ".idle_valid"},  32'(bus.res_valid), 32'd0);
            chk({tag, ".idle_ack"},    32'(bus.ack),       32'd0);
            chk({tag, ".hold_data"},   32'(bus.res_data),  32'(xdata));
            chk({tag, ".hold_err"},    32'(bus.res_err),   32'(err));
            chk({tag, ".hold_ch"},     32'(bus.res_ch),    32'(g));
            chk({tag, ".hold_ch_sel"}, 32'(bus.ch_sel),    32'(g));
         end
         if (drop && c == 2) bus.req = r & ~(N_CH'(1) << g);
         if (k >= 0) begin
            bus.ld    = wave(hi0, fall, rise, k);
            bus.count = (k == e) ? data : CNT_W'($urandom);
         end
         if (c == d && !keep) bus.req = r & ~(N_CH'(1) << g);
      end
      ptr = (g + 1) % N_CH;
   endtask

   initial begin
      int g;
      logic [N_CH-1:0] pend;
      int order[6];
      bus.req   = '0;
      bus.ld    = 1'b0;
      bus.count = '0;

      // Reset state
      rst = 1'b1;
      repeat (3) step();
      chk_reset("reset");
      rst = 1'b0;
      repeat (2) step();
      chk("idle_no_req.busy", 32'(bus.busy), 32'd0);

      // Fairness: all channels requesting continuously
      for (int i = 0; i < 6; i++) begin
         conv("fair", 4'b1111, 1'b1, 1'b0, 1'b0, 0, 9, CNT_W'($urandom), g);
         order[i] = g;
      end
      for (int i = 0; i < 6; i++) chk("fair.order", 32'(order[i]), 32'(i % N_CH));
      bus.req = '0;

      // Single request, ld rises 100 cycles after inicio
      conv("single", 4'b0100, 1'b0, 1'b0, 1'b0, 0, 99, 12'h3A5, g);

      // Timeout, then a normal conversion on the same channel
      conv("timeout", 4'b0001, 1'b0, 1'b0, 1'b0, 0, -1, 12'h000, g);
      conv("after_to", 4'b0001, 1'b0, 1'b0, 1'b0, 0, 5, 12'h5C3, g);

      // Edge in the last WAIT cycle wins over timeout; one later times out
      conv("edge_last", 4'b0010, 1'b0, 1'b0, 1'b0, 0, TO - 1, 12'hABC, g);
      conv("edge_late", 4'b0010, 1'b0, 1'b0, 1'b0, 0, TO, 12'hABC, g);

      // Stale ld high on WAIT entry
      conv("stale", 4'b1000, 1'b0, 1'b0, 1'b1, 3, 8, 12'h010, g);

      // Request dropped during SETTLE still completes
      conv("drop", 4'b0010, 1'b0, 1'b1, 1'b0, 0, 7, 12'h777, g);

      // Reset in the middle of WAIT abandons the conversion silently
      bus.req = 4'b0100;
      bus.ld  = 1'b0;
      repeat (SETTLE + 4) step();
      chk("midwait.busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      step();
      chk_reset("midwait_rst");
      rst     = 1'b0;
      bus.req = '0;
      bus.ld  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst.ack", 32'(bus.ack), 32'd0);
         chk("post_rst.busy", 32'(bus.busy), 32'd0);
      end
      ptr = 0;
      conv("ptr_zero", 4'b1001, 1'b0, 1'b0, 1'b0, 0, 4, 12'h123, g);
      conv("after_rst", 4'b1000, 1'b0, 1'b0, 1'b0, 0, 4, 12'h321, g);

      // Randomized requesters holding req until their ack
      pend = '0;
      for (int i = 0; i < 24; i++) begin
         pend |= N_CH'($urandom_range(0, (1 << N_CH) - 1));
         if (pend == '0) pend = N_CH'(1) << $urandom_range(0, N_CH - 1);
         conv("rand", pend, 1'b1, 1'b0, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 5)),
              ($urandom_range(0, 9) == 0) ? TO + 2 : int'($urandom_range(0, 40)),
              CNT_W'($urandom), g);
         pend &= ~(N_CH'(1) << g);
         bus.req = pend;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
Round-robin scheduler that shares the single dual-slope conversion controller between N_CH analog input channels. For each conversion it selects the analog mux channel and waits a settling interval. It then issues the `inicio` start pulse, waits for the converter's `ld` (result load) edge, and captures the count. It tags the result with its channel and acknowledges the requester. A watchdog aborts conversions that never complete.

Parameters:
N_CH, 4, number of requesting channels (power of two, 2..8)
CH_W, 2, log2(N_CH), width of channel index
CNT_W, 12, width of converter count/result
SETTLE_CYC, 4, mux settling cycles before start (>=1)
TIMEOUT, 8192, max cycles in WAIT before abort (>=2)

Ports:
ck  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req  input  N_CH  per-channel conversion request, level, held until ack
ld  input  1  converter result-load flag (level; rising edge = conversion complete)
count  input  CNT_W  converter result, valid when ld rises
inicio  output  1  one-cycle start pulse to conversion controller
ch_sel  output  CH_W  analog mux channel select
busy  output  1  high in every state except IDLE
res_valid  output  1  one-cycle result strobe
res_ch  output  CH_W  channel of current result
res_data  output  CNT_W  captured count (0 on error)
res_err  output  1  qualifies res_valid: conversion timed out
ack  output  N_CH  one-hot, one-cycle, asserted with res_valid

Behaviour:
- All outputs registered. Reset (any state, mid-conversion included): state=IDLE, inicio=0, ch_sel=0, busy=0, res_valid=0, res_ch=0, res_data=0, res_err=0, ack=0, rr pointer=0, settle/wait counters=0, ld_d=0. An in-flight conversion is abandoned silently; no ack is issued.
- ld_d is a registered copy of ld, updated every cycle. Completion edge is ld=1 && ld_d=0.
- States: IDLE, SETTLE, START, WAIT, DONE.
- IDLE: if req!=0, grant the first set bit searching upward from rr pointer with wrap (pointer=0 after reset, so ch0 wins first). Latch grant into ch_sel and go to SETTLE. No req: stay.
- SETTLE: occupies exactly SETTLE_CYC cycles with ch_sel stable, then goes to START.
- START: one cycle with inicio=1, then WAIT. Wait counter cleared.
- WAIT: inicio=0. On completion edge, capture count into res_data, res_err=0, and go to DONE. Otherwise increment the wait counter. At TIMEOUT cycles in WAIT without an edge, set res_data=0, res_err=1, and go to DONE.
- ld already high on WAIT entry is not a completion; the block waits for it to fall and rise again.
- Edge and timeout in the same cycle: the edge wins (res_err=0).
- DONE: one cycle with res_valid=1, res_ch=ch_sel, ack[ch_sel]=1. Set rr pointer=(ch_sel+1) mod N_CH, then go to IDLE. res_data, res_ch and res_err hold until the next DONE.
- Requests dropped after grant do not cancel: the conversion completes and is reported/acked normally. New or changed req bits are sampled only in IDLE.
- Back-to-back: a req still high after its ack may be re-granted only if no other channel requests (round-robin fairness).
- Latency with req sampled in IDLE at cycle t:
  - ch_sel valid from t+1;
  - inicio at t+1+SETTLE_CYC;
  - res_valid one cycle after the cycle in which the ld edge is observed.
- ch_sel holds its last value in IDLE.

Test Plan:
- Single request: SETTLE_CYC=4, req=0100 at cycle 0; ld rises 100 cycles after inicio with count=0x3A5. Required: ch_sel=2 from cycle 1, inicio only at cycle 5, then res_valid=1, res_ch=2, res_data=0x3A5, res_err=0, ack=0100, each for one cycle.
- Fairness: req=1111 held, each conversion completing after 10 cycles. Required: grant order 0,1,2,3,0,1; exactly one ack per DONE.
- Timeout: TIMEOUT=16, req=0001, ld held 0. Required: DONE exactly 16 cycles after WAIT entry with res_err=1, res_data=0, ack=0001; the next conversion proceeds normally.
- Stale ld: ld=1 at WAIT entry, falls 3 cycles later, rises 5 cycles after that with count=0x010. Required: no early completion; res_data=0x010.
- Reset mid-WAIT: rst pulsed 1 cycle in WAIT. Required: all outputs at reset values the next cycle, no ack, and with req=1000 the next grant is ch3 (pointer back at 0).
- Drop request: req[1] deasserted during SETTLE. Required: conversion still completes with ack=0010.
